// File: rtl/decodificacao_pipe.sv
// RV32I decode stage: decodes at the input, registers decoded fields behind a valid/ready
// handshake, with an optional one-entry skid so in_ready can come straight from a flop.
module decodificacao_pipe #(
  parameter int XLEN           = 32,
  parameter bit MODO_MAGNITUDE = 1'b0,
  parameter bit SKID           = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instrucao,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] immediate,
  output logic            negativo,
  output logic [2:0]      tipo,
  output logic            ilegal
);

  localparam logic [2:0] T_LOAD = 3'b000, T_ALUI = 3'b001, T_S = 3'b010, T_R = 3'b011,
                         T_U    = 3'b100, T_ILEG = 3'b101, T_B = 3'b110, T_J = 3'b111;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            neg;
    logic [2:0]      tipo;
    logic            ilegal;
  } dec_t;

  dec_t               dec;
  logic signed [31:0] raw;
  logic [XLEN-1:0]    imm_sx;

  always_comb begin
    dec        = '0;
    raw        = '0;
    imm_sx     = '0;
    dec.opcode = instrucao[6:0];
    case (instrucao[6:0])
      7'b0000011:             dec.tipo = T_LOAD;
      7'b0010011, 7'b1100111: dec.tipo = T_ALUI;
      7'b0100011:             dec.tipo = T_S;
      7'b0110011:             dec.tipo = T_R;
      7'b0110111, 7'b0010111: dec.tipo = T_U;
      7'b1100011:             dec.tipo = T_B;
      7'b1101111:             dec.tipo = T_J;
      default: begin
        dec.tipo   = T_ILEG;
        dec.ilegal = 1'b1;
      end
    endcase
    case (dec.tipo)
      T_R: begin
        dec.rd     = instrucao[11:7];
        dec.rs1    = instrucao[19:15];
        dec.rs2    = instrucao[24:20];
        dec.funct3 = instrucao[14:12];
        dec.funct7 = instrucao[31:25];
      end
      T_S: begin
        dec.rs1    = instrucao[19:15];
        dec.rs2    = instrucao[24:20];
        dec.funct3 = instrucao[14:12];
        raw = {{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
      end
      T_B: begin
        dec.rs1    = instrucao[19:15];
        dec.rs2    = instrucao[24:20];
        dec.funct3 = instrucao[14:12];
        raw = {{19{instrucao[31]}}, instrucao[31], instrucao[7], instrucao[30:25],
               instrucao[11:8], 1'b0};
      end
      T_U: begin
        dec.rd = instrucao[11:7];
        raw    = {instrucao[31:12], 12'b0};
      end
      T_J: begin
        dec.rd = instrucao[11:7];
        raw = {{11{instrucao[31]}}, instrucao[31], instrucao[19:12], instrucao[20],
               instrucao[30:21], 1'b0};
      end
      default: begin  // load, ALU-I, JALR and illegal words share the I layout
        dec.rd     = instrucao[11:7];
        dec.rs1    = instrucao[19:15];
        dec.funct3 = instrucao[14:12];
        raw = {{20{instrucao[31]}}, instrucao[31:20]};
      end
    endcase
    dec.neg = (dec.tipo != T_R) && instrucao[31];
    imm_sx  = XLEN'(raw);
    dec.imm = (MODO_MAGNITUDE && dec.neg) ? -imm_sx : imm_sx;
  end

  dec_t out_q, out_d, skid_q, skid_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic in_fire, out_fire;

  assign in_ready = SKID ? !skid_v_q : (!out_v_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_v_q && out_ready;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (out_fire) begin
      // in_ready is low while the skid is full, so a refill from skid never races a new word
      if (skid_v_q) begin
        out_d    = skid_q;
        skid_v_d = 1'b0;
      end else if (in_fire) begin
        out_d = dec;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_v_q) begin
        out_d   = dec;
        out_v_d = 1'b1;
      end else if (SKID) begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid = out_v_q;
  assign opcode    = out_q.opcode;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign funct3    = out_q.funct3;
  assign funct7    = out_q.funct7;
  assign immediate = out_q.imm;
  assign negativo  = out_q.neg;
  assign tipo      = out_q.tipo;
  assign ilegal    = out_q.ilegal;

endmodule
